// File: rtl/split_pkg.sv
// split_pkg: shared defaults and state encoding
// for the split verdict collector.
package split_pkg;

  localparam int NUM_SPLITS_DEF = 8;
  localparam int CNT_W_DEF      = 32;
  localparam int TAG_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/split_verdict_collector_sat_counter.sv
// sat_counter: saturating up-counter with
// synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // count up on inc, stick at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/split_verdict_collector.sv
// split_verdict_collector: combines per-split
// verdicts, counts outcomes, stops at target.
module split_verdict_collector
  import split_pkg::*;
#(
  parameter int NUM_SPLITS = NUM_SPLITS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TAG_W      = TAG_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            target_sat,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_SPLITS-1:0]       in_split_x,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        sat_valid,
  output logic [TAG_W-1:0]            sat_tag,
  output logic [CNT_W-1:0]            sample_cnt,
  output logic [CNT_W-1:0]            sat_cnt,
  output logic [NUM_SPLITS*CNT_W-1:0] fail_cnt,
  output logic                        busy,
  output logic                        done
);

  state_t           state;
  logic [CNT_W-1:0] target;
  logic             accept;
  logic             all_ok;
  logic             clr;
  logic [CNT_W-1:0] sat_next;

  assign accept = in_valid && in_ready;
  assign all_ok = &in_split_x;
  assign clr    = start && !abort &&
                  (state != RUN);

  // value sat_cnt will hold after this accept
  assign sat_next = (&sat_cnt) ? sat_cnt
                  : sat_cnt + CNT_W'(1);

  // run control with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            target <= target_sat;
            if (target_sat == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept && all_ok &&
              sat_next >= target) begin
            state    <= DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // one-cycle pulse with the satisfying tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_valid <= 1'b0;
      sat_tag   <= '0;
    end else begin
      sat_valid <= accept && all_ok;
      if (accept && all_ok) begin
        sat_tag <= in_tag;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept),
    .q     (sample_cnt)
  );

  sat_counter #(.W(CNT_W)) u_sat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && all_ok),
    .q     (sat_cnt)
  );

  for (genvar i = 0; i < NUM_SPLITS; i++) begin : g_fail
    sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (accept && !in_split_x[i]),
      .q     (fail_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_split_verdict_collector.sv
// tb_split_verdict_collector: directed vectors
// with hand-computed expectations.
module tb_split_verdict_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] target_sat;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_split_x;
  logic [15:0] in_tag;
  logic        sat_valid;
  logic [15:0] sat_tag;
  logic [31:0] sample_cnt, sat_cnt;
  logic [255:0] fail_cnt;
  logic        busy, done;

  logic        start2, abort2;
  logic [3:0]  target2;
  logic        valid2;
  logic        ready2;
  logic [7:0]  x2;
  logic [15:0] tag2;
  logic        sat_valid2;
  logic [15:0] sat_tag2;
  logic [3:0]  sample_cnt2, sat_cnt2;
  logic [31:0] fail_cnt2;
  logic        busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  split_verdict_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .target_sat (target_sat),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_split_x (in_split_x),
    .in_tag     (in_tag),
    .sat_valid  (sat_valid),
    .sat_tag    (sat_tag),
    .sample_cnt (sample_cnt),
    .sat_cnt    (sat_cnt),
    .fail_cnt   (fail_cnt),
    .busy       (busy),
    .done       (done)
  );

  split_verdict_collector #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .abort      (abort2),
    .target_sat (target2),
    .in_valid   (valid2),
    .in_ready   (ready2),
    .in_split_x (x2),
    .in_tag     (tag2),
    .sat_valid  (sat_valid2),
    .sat_tag    (sat_tag2),
    .sample_cnt (sample_cnt2),
    .sat_cnt    (sat_cnt2),
    .fail_cnt   (fail_cnt2),
    .busy       (busy2),
    .done       (done2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fc(input int i);
    return fail_cnt[i*32 +: 32];
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 0; abort = 0; target_sat = 0;
    in_valid = 0; in_split_x = 0; in_tag = 0;
    start2 = 0; abort2 = 0; target2 = 0;
    valid2 = 0; x2 = 0; tag2 = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("rst_ready", in_ready, 0);
    chk("rst_sat_valid", sat_valid, 0);
    chk("rst_sat_tag", sat_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample", sample_cnt, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_fail", fail_cnt, 0);

    in_valid = 1; in_split_x = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_ready", in_ready, 0);
    end
    chk("idle_sample", sample_cnt, 0);
    chk("idle_sat", sat_cnt, 0);
    in_valid = 0;

    target2 = 4'd15; start2 = 1;
    tick();
    start2 = 0;
    chk("w4_busy", busy2, 1);
    valid2 = 1; x2 = 8'h00;
    for (int k = 0; k < 20; k++) tick();
    valid2 = 0;
    chk("w4_sample", sample_cnt2, 15);
    chk("w4_fail0", fail_cnt2[3:0], 15);
    chk("w4_fail7", fail_cnt2[31:28], 15);
    chk("w4_sat", sat_cnt2, 0);

    target_sat = 3; start = 1;
    tick();
    start = 0;
    chk("t3_busy", busy, 1);
    chk("t3_ready", in_ready, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_split_x = 8'hFF;
      in_tag = 16'(10 + k);
      tick();
      chk("t3_sv", sat_valid, k < 3);
      if (k < 3) chk("t3_tag", sat_tag, 10 + k);
      chk("t3_rdy", in_ready, k < 2);
    end
    in_valid = 0;
    chk("t3_sample", sample_cnt, 3);
    chk("t3_sat", sat_cnt, 3);
    chk("t3_done", done, 1);
    chk("t3_busy_end", busy, 0);

    target_sat = 100; start = 1;
    tick();
    start = 0;
    chk("t100_clr", sample_cnt, 0);
    in_valid = 1;
    in_split_x = 8'hFF; tick();
    in_split_x = 8'hFE; tick();
    in_split_x = 8'h7F; tick();
    in_split_x = 8'h00; tick();
    in_valid = 0;
    tick();
    chk("t100_sample", sample_cnt, 4);
    chk("t100_sat", sat_cnt, 1);
    chk("t100_fail0", fc(0), 2);
    chk("t100_fail7", fc(7), 2);
    chk("t100_fail3", fc(3), 1);
    chk("t100_fail1", fc(1), 1);
    chk("t100_busy", busy, 1);

    abort = 1;
    tick();
    abort = 0;
    chk("ab_ready", in_ready, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_keep", sample_cnt, 4);
    chk("ab_keep_f0", fc(0), 2);

    target_sat = 0; start = 1;
    in_valid = 1; in_split_x = 8'hFF;
    tick();
    start = 0;
    chk("t0_done", done, 1);
    chk("t0_ready", in_ready, 0);
    chk("t0_clr", sample_cnt, 0);
    tick();
    chk("t0_noacc", sample_cnt, 0);

    target_sat = 1; start = 1;
    in_tag = 16'd77;
    tick();
    start = 0;
    chk("t1_clr", sat_cnt, 0);
    chk("t1_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("t1_sv", sat_valid, 1);
    chk("t1_tag", sat_tag, 77);
    chk("t1_sat", sat_cnt, 1);
    chk("t1_done", done, 1);
    tick();
    chk("t1_sv_pulse", sat_valid, 0);

    abort = 1; start = 1; target_sat = 5;
    tick();
    abort = 0; start = 0;
    chk("as_done", done, 0);
    chk("as_busy", busy, 0);
    chk("as_keep", sat_cnt, 1);

    target_sat = 5; start = 1;
    tick();
    start = 0;
    in_valid = 1; in_split_x = 8'hFF;
    in_tag = 16'd1;
    tick();
    in_valid = 0;
    chk("rs_sat", sat_cnt, 1);
    start = 1; target_sat = 1;
    tick();
    start = 0;
    chk("rs_ignored", sat_cnt, 1);
    chk("rs_busy", busy, 1);

    in_valid = 1; in_split_x = 8'hFF;
    in_tag = 16'd2; rst_n = 0;
    tick();
    rst_n = 1; in_valid = 0;
    chk("mr_sv", sat_valid, 0);
    chk("mr_tag", sat_tag, 0);
    chk("mr_sample", sample_cnt, 0);
    chk("mr_sat", sat_cnt, 0);
    chk("mr_fail", fail_cnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", in_ready, 0);
    chk("mr_w4", sample_cnt2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
